// File: rtl/spi_slave_tx_if.sv
// Bus bundle for spi_slave_tx: local write port, host link inputs and status outputs.
interface spi_slave_tx_if #(
    parameter int DATA_WIDTH = 8,
    parameter int BYTE_STORE = 20
);
    localparam int CW = $clog2(BYTE_STORE + 1);

    logic                  load_iv;
    logic [DATA_WIDTH-1:0] load_id;
    logic                  clr_flags;
    logic                  clk_in;
    logic                  sel_in;
    logic [DATA_WIDTH-1:0] data_out;
    logic [CW-1:0]         fifo_count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  underrun;
    logic                  tx_done;

    modport slave (
        input  load_iv, load_id, clr_flags, clk_in, sel_in,
        output data_out, fifo_count, full, empty, overflow, underrun, tx_done
    );

    modport master (
        output load_iv, load_id, clr_flags, clk_in, sel_in,
        input  data_out, fifo_count, full, empty, overflow, underrun, tx_done
    );
endinterface

// File: rtl/spi_slave_tx.sv
// Slave-side transmitter: FIFO fed by load_iv, head presented on data_out, one pop per clk_in rise.
// States: IDLE | deselected, data_out held 0 ;  ACTIVE | selected, FIFO head (or fill) on data_out
module spi_slave_tx #(
    parameter int                    DATA_WIDTH = 8,
    parameter int                    BYTE_STORE = 20,
    parameter logic [DATA_WIDTH-1:0] FILL_BYTE  = DATA_WIDTH'(8'hFF)
) (
    input  logic          clk,
    input  logic          rst,
    spi_slave_tx_if.slave bus
);
    localparam int CW = $clog2(BYTE_STORE + 1);
    localparam int PW = (BYTE_STORE > 1) ? $clog2(BYTE_STORE) : 1;

    typedef enum logic {IDLE, ACTIVE} state_t;

    state_t                state_q, state_d;
    logic                  clk_q, sel_q;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH-1:0] mem_q [BYTE_STORE];
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d, head_next;
    logic                  overflow_q, overflow_d;
    logic                  underrun_q, underrun_d;
    logic                  tx_done_q, tx_done_d;
    logic                  sel_fall, sel_rise, clk_rise;
    logic                  is_full, is_empty, consume, pop, push;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BYTE_STORE - 1)) ? '0 : p + 1'b1;
    endfunction

    assign sel_fall = sel_q & ~bus.sel_in;
    assign sel_rise = ~sel_q & bus.sel_in;
    assign clk_rise = ~clk_q & bus.clk_in;

    assign is_full  = (count_q == CW'(BYTE_STORE));
    assign is_empty = (count_q == '0);
    // A deselect edge wins over a coincident link clock edge.
    assign consume  = (state_q == ACTIVE) & clk_rise & ~sel_rise;
    assign pop      = consume & ~is_empty;
    assign push     = bus.load_iv & (~is_full | pop);

    always_comb begin
        wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
        // Head after this cycle's update; a byte landing in the head slot bypasses the array.
        head_next = (push && (wr_ptr_q == rd_ptr_d)) ? bus.load_id : mem_q[rd_ptr_d];

        overflow_d = (bus.load_iv & is_full & ~pop) | (overflow_q & ~bus.clr_flags);
        underrun_d = (consume & is_empty) | (underrun_q & ~bus.clr_flags);
    end

    always_comb begin
        state_d    = state_q;
        data_out_d = data_out_q;
        tx_done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                data_out_d = '0;
                if (sel_fall) begin
                    state_d    = ACTIVE;
                    data_out_d = (count_d == '0) ? FILL_BYTE : head_next;
                end
            end
            ACTIVE: begin
                if (sel_rise) begin
                    state_d    = IDLE;
                    data_out_d = '0;
                    tx_done_d  = 1'b1;
                end else begin
                    data_out_d = (count_d == '0) ? FILL_BYTE : head_next;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_q      <= 1'b0;
            sel_q      <= 1'b1;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
            overflow_q <= 1'b0;
            underrun_q <= 1'b0;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            clk_q      <= bus.clk_in;
            sel_q      <= bus.sel_in;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
            overflow_q <= overflow_d;
            underrun_q <= underrun_d;
            tx_done_q  <= tx_done_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= bus.load_id;
        end
    end

    assign bus.data_out   = data_out_q;
    assign bus.fifo_count = count_q;
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;
    assign bus.overflow   = overflow_q;
    assign bus.underrun   = underrun_q;
    assign bus.tx_done    = tx_done_q;
endmodule
